dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller placed between the pipelined MIPS core's MEM stage and the block-wide data memory. It serves 32-bit word loads and stores from the core, stalls the pipeline on misses, and moves whole 256-bit (8-word) lines to and from memory over a block request/ready handshake.

---
 rtl/dcache_ctrl_if.sv | 26 ++
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Bus between the data cache controller, the core's MEM stage and block-wide data memory.
// The slave side is the cache controller; the master side is the core plus memory.
interface dcache_ctrl_if;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  data_address_2DM;
    logic [31:0]  data_write_2DM;
    logic [31:0]  data_read_fDM;
    logic         stall;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [31:0]  blk_address;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         mem_ready;

    modport slave (
        input  MemRead, MemWrite, data_address_2DM, data_write_2DM, block_read_fDM, mem_ready,
        output data_read_fDM, stall, dBlkRead, dBlkWrite, blk_address, block_write_2DM
    );

    modport master (
        output MemRead, MemWrite, data_address_2DM, data_write_2DM, block_read_fDM, mem_ready,
        input  data_read_fDM, stall, dBlkRead, dBlkWrite, blk_address, block_write_2DM
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 8-word lines.
// Misses stall the core while whole lines move over a block request/ready handshake.
module dcache_ctrl #(
    parameter int NUM_LINES = 8
) (
    input logic          CLK,
    input logic          RESET,
    dcache_ctrl_if.slave bus
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX - 5;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state;
    state_t next_state;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [255:0]         data_arr [NUM_LINES];

    logic [2:0]       offset;
    logic [IDX-1:0]   index;
    logic [TAG_W-1:0] tag;
    logic             request;
    logic             hit;
    logic             victim_dirty;
    logic             write_hit;
    logic             wb_done;
    logic             fill_done;
    logic             stall_now;
    logic             fill_req;
    logic             wb_req;
    logic [31:0]      mem_addr;
    logic [255:0]     victim_line;
    logic [31:0]      load_data;
    logic             unused_addr_bits;

    assign offset           = bus.data_address_2DM[4:2];
    assign index            = bus.data_address_2DM[IDX+4:5];
    assign tag              = bus.data_address_2DM[31:IDX+5];
    assign unused_addr_bits = ^bus.data_address_2DM[1:0];
    assign request          = bus.MemRead | bus.MemWrite;
    assign hit              = request && valid[index] && (tag_arr[index] == tag);
    assign victim_dirty     = valid[index] && dirty[index];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A store with MemRead also high is treated purely as a store, so it returns no load data.
    always_comb begin
        next_state  = state;
        stall_now   = 1'b0;
        fill_req    = 1'b0;
        wb_req      = 1'b0;
        mem_addr    = '0;
        victim_line = '0;
        load_data   = '0;
        write_hit   = 1'b0;
        wb_done     = 1'b0;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (bus.MemWrite) begin
                        write_hit = 1'b1;
                    end else begin
                        load_data = data_arr[index][{offset, 5'b0} +: 32];
                    end
                end else if (request) begin
                    stall_now  = 1'b1;
                    next_state = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                stall_now   = 1'b1;
                wb_req      = 1'b1;
                mem_addr    = {tag_arr[index], index, 5'b0};
                victim_line = data_arr[index];
                if (bus.mem_ready) begin
                    wb_done    = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                stall_now = 1'b1;
                fill_req  = 1'b1;
                mem_addr  = {tag, index, 5'b0};
                if (bus.mem_ready) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // While reset is held, a pending request must not show as a miss stall.
        if (!RESET) begin
            stall_now = 1'b0;
            load_data = '0;
            write_hit = 1'b0;
        end
    end

    // Tag and data storage carry no reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge CLK) begin
        if (write_hit) begin
            data_arr[index][{offset, 5'b0} +: 32] <= bus.data_write_2DM;
        end
        if (fill_done) begin
            data_arr[index] <= bus.block_read_fDM;
            tag_arr[index]  <= tag;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (write_hit) begin
                dirty[index] <= 1'b1;
            end
            if (wb_done) begin
                dirty[index] <= 1'b0;
            end
            if (fill_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
        end
    end

    assign bus.stall           = stall_now;
    assign bus.dBlkRead        = fill_req;
    assign bus.dBlkWrite       = wb_req;
    assign bus.blk_address     = mem_addr;
    assign bus.block_write_2DM = victim_line;
    assign bus.data_read_fDM   = load_data;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset corner case, then random
// accesses checked against a word-level memory image and a tag/valid/dirty cache model.
module tb_dcache_ctrl;
    logic CLK = 1'b0;
    logic RESET;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.NUM_LINES(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Backing memory covers addresses 0x000-0x3FF: 32 lines of 8 words.
    logic [255:0] memLine [32];

    int fixedWait = 0;
    bit noise     = 1'b0;
    bit inXfer    = 1'b0;
    int waitLeft  = 0;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waitCyc;
        int          expStall;
        int          expRd;
        int          expWb;
        logic [31:0] expData;
        bit          chkData;
        logic [31:0] expWbAddr;
        logic [31:0] expWbWord2;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory model: chooses a wait per transfer, then raises mem_ready for one cycle.
    initial begin
        bus.mem_ready      = 1'b0;
        bus.block_read_fDM = '0;
        forever begin
            @(negedge CLK);
            if (bus.dBlkRead || bus.dBlkWrite) begin
                if (!inXfer) begin
                    inXfer   = 1'b1;
                    waitLeft = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
                end
                if (waitLeft == 0) begin
                    bus.mem_ready = 1'b1;
                    inXfer        = 1'b0;
                    if (bus.dBlkWrite) begin
                        memLine[bus.blk_address[9:5]] = bus.block_write_2DM;
                    end else begin
                        bus.block_read_fDM = memLine[bus.blk_address[9:5]];
                    end
                end else begin
                    bus.mem_ready      = 1'b0;
                    bus.block_read_fDM = {8{$urandom}};
                    waitLeft--;
                end
            end else begin
                inXfer        = 1'b0;
                bus.mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // kind: 0 load, 1 store, 2 both MemRead and MemWrite. Starts just after a rising edge.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 output int stallCyc, output int rdCyc, output int wbCyc,
                                 output logic [31:0] rdAddr, output logic [31:0] wbAddr,
                                 output logic [255:0] wbLine, output logic [31:0] rdata);
        bit done = 1'b0;
        stallCyc = 0;
        rdCyc    = 0;
        wbCyc    = 0;
        rdAddr   = '0;
        wbAddr   = '0;
        wbLine   = '0;
        rdata    = '0;
        bus.MemRead          = (kind != 1);
        bus.MemWrite         = (kind != 0);
        bus.data_address_2DM = addr;
        bus.data_write_2DM   = wdata;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge CLK);
            checkOutput("blk read/write exclusive", {255'd0, bus.dBlkRead & bus.dBlkWrite}, '0);
            if (!bus.stall) begin
                rdata = bus.data_read_fDM;
                done  = 1'b1;
                break;
            end
            stallCyc++;
            if (bus.dBlkRead) begin
                rdCyc++;
                rdAddr = bus.blk_address;
            end
            if (bus.dBlkWrite) begin
                wbCyc++;
                wbAddr = bus.blk_address;
                wbLine = bus.block_write_2DM;
            end
            @(posedge CLK);
            #1;
        end
        checkOutput("access completes", {255'd0, done}, 256'd1);
        @(posedge CLK);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    logic [31:0]  gold [256];
    logic [1:0]   mTag [8];
    logic [7:0]   mValid;
    logic [7:0]   mDirty;

    initial begin
        int stallCyc, rdCyc, wbCyc;
        logic [31:0] rdAddr, wbAddr, rdata, addr, wdata;
        logic [255:0] wbLine, expLine;
        logic [7:0] w;
        logic [2:0] idx;
        logic [1:0] tg;
        bit hit, wb;
        int kind;

        for (int l = 0; l < 32; l++) begin
            for (int k = 0; k < 8; k++) begin
                memLine[l][k*32 +: 32] = 32'h5000_0000 | (l << 8) | k;
            end
        end
        for (int k = 0; k < 8; k++) begin
            memLine[2][k*32 +: 32] = 32'h1111_1111 * (k + 1);
        end

        vecs[0]  = '{0, 32'h040, 32'h0,         2, 4, 3, 0, 32'h1111_1111, 1'b1, 32'h0,  32'h0};
        vecs[1]  = '{0, 32'h044, 32'h0,         0, 0, 0, 0, 32'h2222_2222, 1'b1, 32'h0,  32'h0};
        vecs[2]  = '{1, 32'h048, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0,         1'b1, 32'h0,  32'h0};
        vecs[3]  = '{0, 32'h048, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 1'b1, 32'h0,  32'h0};
        vecs[4]  = '{0, 32'h140, 32'h0,         1, 5, 2, 2, 32'h5000_0A00, 1'b1, 32'h40, 32'hDEAD_BEEF};
        vecs[5]  = '{0, 32'h14C, 32'h0,         0, 0, 0, 0, 32'h5000_0A03, 1'b1, 32'h0,  32'h0};
        vecs[6]  = '{1, 32'h284, 32'h1234_5678, 0, 2, 1, 0, 32'h0,         1'b1, 32'h0,  32'h0};
        vecs[7]  = '{0, 32'h284, 32'h0,         0, 0, 0, 0, 32'h1234_5678, 1'b1, 32'h0,  32'h0};
        vecs[8]  = '{0, 32'h280, 32'h0,         0, 0, 0, 0, 32'h5000_1400, 1'b1, 32'h0,  32'h0};
        vecs[9]  = '{0, 32'h041, 32'h0,         0, 2, 1, 0, 32'h1111_1111, 1'b1, 32'h0,  32'h0};
        vecs[10] = '{0, 32'h04A, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 1'b1, 32'h0,  32'h0};

        RESET                = 1'b0;
        bus.MemRead          = 1'b0;
        bus.MemWrite         = 1'b0;
        bus.data_address_2DM = '0;
        bus.data_write_2DM   = '0;
        #12;
        checkOutput("reset stall",     {255'd0, bus.stall},     '0);
        checkOutput("reset dBlkRead",  {255'd0, bus.dBlkRead},  '0);
        checkOutput("reset dBlkWrite", {255'd0, bus.dBlkWrite}, '0);
        checkOutput("reset blk_address", {224'd0, bus.blk_address}, '0);
        checkOutput("reset block_write", bus.block_write_2DM, '0);
        checkOutput("reset data_read", {224'd0, bus.data_read_fDM}, '0);
        #10;
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 11; i++) begin
            fixedWait = vecs[i].waitCyc;
            applyStimulus(vecs[i].kind, vecs[i].addr, vecs[i].wdata,
                          stallCyc, rdCyc, wbCyc, rdAddr, wbAddr, wbLine, rdata);
            checkOutput($sformatf("vec%0d stall cycles", i), 256'(stallCyc), 256'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d dBlkRead cycles", i), 256'(rdCyc), 256'(vecs[i].expRd));
            checkOutput($sformatf("vec%0d dBlkWrite cycles", i), 256'(wbCyc), 256'(vecs[i].expWb));
            if (vecs[i].chkData) begin
                checkOutput($sformatf("vec%0d data_read", i), {224'd0, rdata}, {224'd0, vecs[i].expData});
            end
            if (vecs[i].expRd > 0) begin
                checkOutput($sformatf("vec%0d fill address", i), {224'd0, rdAddr},
                            {224'd0, vecs[i].addr & 32'hFFFF_FFE0});
            end
            if (vecs[i].expWb > 0) begin
                checkOutput($sformatf("vec%0d writeback address", i), {224'd0, wbAddr}, {224'd0, vecs[i].expWbAddr});
                checkOutput($sformatf("vec%0d writeback word2", i), {224'd0, wbLine[95:64]},
                            {224'd0, vecs[i].expWbWord2});
            end
        end

        // Reset in the middle of a fill: requests drop at once and the line is not kept.
        fixedWait            = 5;
        bus.MemRead          = 1'b1;
        bus.MemWrite         = 1'b0;
        bus.data_address_2DM = 32'h0A0;
        @(negedge CLK);
        checkOutput("midfill miss stall", {255'd0, bus.stall}, 256'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("midfill dBlkRead", {255'd0, bus.dBlkRead}, 256'd1);
        #1;
        RESET = 1'b0;
        #1;
        checkOutput("midfill reset dBlkRead", {255'd0, bus.dBlkRead}, '0);
        checkOutput("midfill reset stall", {255'd0, bus.stall}, '0);
        checkOutput("midfill reset blk_address", {224'd0, bus.blk_address}, '0);
        @(posedge CLK);
        #1;
        bus.MemRead = 1'b0;
        #1;
        RESET     = 1'b1;
        fixedWait = 0;
        applyStimulus(0, 32'h0A0, 32'h0, stallCyc, rdCyc, wbCyc, rdAddr, wbAddr, wbLine, rdata);
        checkOutput("reload after reset stall", 256'(stallCyc), 256'd2);
        checkOutput("reload after reset dBlkRead", 256'(rdCyc), 256'd1);
        checkOutput("reload after reset data", {224'd0, rdata}, {224'd0, 32'h5000_0500});

        // Fresh reset, then random traffic against the architectural model.
        RESET = 1'b0;
        #10;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 256; i++) begin
            gold[i] = memLine[i >> 3][(i & 7) * 32 +: 32];
        end
        mValid    = '0;
        mDirty    = '0;
        noise     = 1'b1;
        fixedWait = -1;
        for (int n = 0; n < 300; n++) begin
            kind  = int'($urandom_range(0, 2));
            w     = 8'($urandom_range(0, 255));
            addr  = {22'd0, w, 2'($urandom)};
            wdata = $urandom;
            idx   = w[5:3];
            tg    = w[7:6];
            hit   = mValid[idx] && (mTag[idx] == tg);
            wb    = !hit && mValid[idx] && mDirty[idx];
            for (int k = 0; k < 8; k++) begin
                expLine[k*32 +: 32] = gold[{mTag[idx], idx, 3'(k)}];
            end
            applyStimulus(kind, addr, wdata, stallCyc, rdCyc, wbCyc, rdAddr, wbAddr, wbLine, rdata);
            checkOutput("rnd fill occurred", {255'd0, rdCyc > 0}, {255'd0, !hit});
            checkOutput("rnd writeback occurred", {255'd0, wbCyc > 0}, {255'd0, wb});
            checkOutput("rnd stall cycles", 256'(stallCyc), hit ? 256'd0 : 256'(1 + rdCyc + wbCyc));
            if (!hit) begin
                checkOutput("rnd fill address", {224'd0, rdAddr}, {224'd0, 22'd0, w[7:3], 5'd0});
            end
            if (wb) begin
                checkOutput("rnd writeback address", {224'd0, wbAddr}, {224'd0, 22'd0, mTag[idx], idx, 5'd0});
                checkOutput("rnd writeback line", wbLine, expLine);
            end
            if (kind == 0) begin
                checkOutput("rnd load data", {224'd0, rdata}, {224'd0, gold[w]});
            end else if (kind == 1) begin
                checkOutput("rnd store data_read", {224'd0, rdata}, '0);
            end
            if (!hit) begin
                mValid[idx] = 1'b1;
                mTag[idx]   = tg;
                mDirty[idx] = 1'b0;
            end
            if (kind != 0) begin
                gold[w]     = wdata;
                mDirty[idx] = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end
endmodule
